// File: rtl/medidor_periodo_us.sv
`default_nettype none
// ============================================================================
// medidor_periodo_us: measures the period of senal_in in whole microseconds,
// publishing each completed period on a one-cycle strobe.      Revision: 1.0
// ============================================================================
module medidor_periodo_us #(
  parameter int CLK_POR_US = 25,
  parameter int ANCHO      = 16
) (
  input  logic             clock_FPGA,
  input  logic             reset_FPGA_n,
  input  logic             senal_in,
  input  logic             habilitar,
  output logic [ANCHO-1:0] periodo_us,
  output logic             dato_valido,
  output logic             desborde,
  output logic             sin_senal
);

  localparam int              PW          = $clog2(CLK_POR_US);
  localparam logic [PW-1:0]   c_presc_fin = PW'(CLK_POR_US - 1);
  localparam logic [ANCHO-1:0] c_max      = '1;

  localparam logic [1:0] c_espera_bajo = 2'd0;
  localparam logic [1:0] c_armado      = 2'd1;
  localparam logic [1:0] c_midiendo    = 2'd2;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       sinc_lleno_q;
  logic [1:0]       estado_q, estado_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [ANCHO-1:0] cont_q, cont_d;
  logic             sat_q, sat_d;
  logic [ANCHO-1:0] periodo_q, periodo_d;
  logic             valido_q, valido_d;
  logic             desborde_q, desborde_d;
  logic             sin_senal_q, sin_senal_d;

  logic             flanco;
  logic             tick_us;
  logic [ANCHO:0]   suma;
  logic             suma_llena;
  logic             en_medida;
  logic             publicar;
  logic             reiniciar;

  // sinc_lleno_q marks when s2_q holds a real sample rather than its reset
  // value, so a wave high at reset release is not mistaken for a low level.
  always_ff @(posedge clock_FPGA or negedge reset_FPGA_n) begin
    if (!reset_FPGA_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      sinc_lleno_q <= 2'b00;
    end else begin
      s1_q         <= senal_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      sinc_lleno_q <= {sinc_lleno_q[0], 1'b1};
    end
  end

  assign flanco     = s2_q & ~s3_q;
  assign tick_us    = (presc_q == c_presc_fin);
  assign suma       = {1'b0, cont_q} + {{ANCHO{1'b0}}, tick_us};
  assign suma_llena = (suma >= {1'b0, c_max});

  always_ff @(posedge clock_FPGA or negedge reset_FPGA_n) begin
    if (!reset_FPGA_n) begin
      estado_q <= c_espera_bajo;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    if (!habilitar) begin
      estado_d = c_espera_bajo;
    end else begin
      case (estado_q)
        c_espera_bajo: if (sinc_lleno_q[1] && !s2_q) estado_d = c_armado;
        c_armado:      if (flanco) estado_d = c_midiendo;
        c_midiendo:    estado_d = c_midiendo;
        default:       estado_d = c_espera_bajo;
      endcase
    end
  end

  always_comb begin
    en_medida = 1'b0;
    case (estado_q)
      c_midiendo: en_medida = 1'b1;
      default:    en_medida = 1'b0;
    endcase
    publicar  = habilitar & en_medida & flanco;
    reiniciar = ~habilitar | ~en_medida | flanco;
  end

  // Outside MIDIENDO the counters are parked at zero; an edge restarts them.
  always_comb begin
    presc_d = presc_q;
    cont_d  = cont_q;
    sat_d   = sat_q;
    if (reiniciar) begin
      presc_d = '0;
      cont_d  = '0;
      sat_d   = 1'b0;
    end else if (tick_us) begin
      presc_d = '0;
      if (cont_q == c_max) begin
        sat_d = 1'b1;
      end else begin
        cont_d = cont_q + 1'b1;
        if (cont_q == c_max - 1'b1) sat_d = 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // A tick coinciding with the edge belongs to the period just closed.
  always_comb begin
    periodo_d  = periodo_q;
    desborde_d = desborde_q;
    valido_d   = 1'b0;
    if (publicar) begin
      valido_d   = 1'b1;
      periodo_d  = (sat_q || suma_llena) ? c_max : suma[ANCHO-1:0];
      desborde_d = sat_q | (tick_us & suma_llena);
    end
    sin_senal_d = (estado_d != c_midiendo) || (cont_d == c_max);
  end

  always_ff @(posedge clock_FPGA or negedge reset_FPGA_n) begin
    if (!reset_FPGA_n) begin
      presc_q     <= '0;
      cont_q      <= '0;
      sat_q       <= 1'b0;
      periodo_q   <= '0;
      valido_q    <= 1'b0;
      desborde_q  <= 1'b0;
      sin_senal_q <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      cont_q      <= cont_d;
      sat_q       <= sat_d;
      periodo_q   <= periodo_d;
      valido_q    <= valido_d;
      desborde_q  <= desborde_d;
      sin_senal_q <= sin_senal_d;
    end
  end

  assign periodo_us  = periodo_q;
  assign dato_valido = valido_q;
  assign desborde    = desborde_q;
  assign sin_senal   = sin_senal_q;

endmodule
`default_nettype wire

// File: tb/tb_medidor_periodo_us.sv
`default_nettype none
// tb_medidor_periodo_us: two instances (16-bit and 8-bit counters) driven by
// one wave; strobes are predicted from sampled rising-edge timestamps.
module tb_medidor_periodo_us;

  localparam int C_CLK = 25;

  logic clock_FPGA   = 1'b0;
  logic reset_FPGA_n = 1'b1;
  logic senal_in     = 1'b1;
  logic habilitar    = 1'b0;

  logic [15:0] periodo_a;
  logic [7:0]  periodo_b;
  logic        valido_a, valido_b, des_a, des_b, sin_a, sin_b;

  always #20 clock_FPGA = ~clock_FPGA;

  medidor_periodo_us #(.CLK_POR_US(C_CLK), .ANCHO(16)) dut_a (
    .clock_FPGA  (clock_FPGA),
    .reset_FPGA_n(reset_FPGA_n),
    .senal_in    (senal_in),
    .habilitar   (habilitar),
    .periodo_us  (periodo_a),
    .dato_valido (valido_a),
    .desborde    (des_a),
    .sin_senal   (sin_a)
  );

  medidor_periodo_us #(.CLK_POR_US(C_CLK), .ANCHO(8)) dut_b (
    .clock_FPGA  (clock_FPGA),
    .reset_FPGA_n(reset_FPGA_n),
    .senal_in    (senal_in),
    .habilitar   (habilitar),
    .periodo_us  (periodo_b),
    .dato_valido (valido_b),
    .desborde    (des_b),
    .sin_senal   (sin_b)
  );

  int          checks  = 0;
  int          errors  = 0;
  int          strobes = 0;
  int unsigned cyc     = 0;

  task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nom, act, exp);
    end
  endtask

  // Reference model: each sampled rising edge closes the period opened by the
  // previous one; the strobe is due two clock edges after the sample.
  typedef struct {
    int unsigned due;
    int unsigned per_a;
    int unsigned per_b;
    bit          des_a;
    bit          des_b;
  } esp_t;

  esp_t        q[$];
  esp_t        e_chk;
  bit          prev    = 1'b1;
  bit          hay_ult = 1'b0;
  int unsigned ult     = 0;

  function automatic esp_t esperado(input int unsigned d, input int unsigned due);
    esp_t        e;
    int unsigned us;
    us      = d / C_CLK;
    e.due   = due;
    e.per_a = (us > 65535) ? 65535 : us;
    e.des_a = (us >= 65535);
    e.per_b = (us > 255) ? 255 : us;
    e.des_b = (us >= 255);
    return e;
  endfunction

  always @(posedge clock_FPGA) begin
    cyc <= cyc + 1;
    if (!reset_FPGA_n || !habilitar) begin
      prev    <= 1'b1;
      hay_ult <= 1'b0;
      if (!reset_FPGA_n) q.delete();
    end else begin
      prev <= senal_in;
      if (senal_in && !prev) begin
        hay_ult <= 1'b1;
        ult     <= cyc + 1;
        if (hay_ult) q.push_back(esperado(cyc + 1 - ult, cyc + 3));
      end
    end
  end

  always @(negedge clock_FPGA) begin
    if (reset_FPGA_n) begin
      while (q.size() != 0 && q[0].due < cyc) begin
        chk("strobe_missing_due", cyc, q[0].due);
        e_chk = q.pop_front();
      end
      if (valido_a || valido_b) begin
        strobes++;
        chk("strobe_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e_chk = q.pop_front();
          chk("strobe_cycle", cyc, e_chk.due);
          chk("valido_a", valido_a, 1);
          chk("valido_b", valido_b, 1);
          chk("periodo_a", periodo_a, e_chk.per_a);
          chk("desborde_a", des_a, e_chk.des_a);
          chk("periodo_b", periodo_b, e_chk.per_b);
          chk("desborde_b", des_b, e_chk.des_b);
          chk("sin_senal_a_strobe", sin_a, 0);
          chk("sin_senal_b_strobe", sin_b, 0);
        end
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock_FPGA);
  endtask

  task automatic pulso(input int alto, input int bajo);
    senal_in = 1'b1;
    ciclos(alto);
    senal_in = 1'b0;
    ciclos(bajo);
  endtask

  typedef struct {
    int unsigned per_ciclos;
    int unsigned n;
    int unsigned exp_a;
    bit          exp_des_a;
    int unsigned exp_b;
    bit          exp_des_b;
  } vec_t;

  vec_t tabla [9];
  int   s0;

  initial begin
    tabla[0] = '{1000,  5, 40,  1'b0, 40,  1'b0};
    tabla[1] = '{1012,  3, 40,  1'b0, 40,  1'b0};
    tabla[2] = '{1025,  3, 41,  1'b0, 41,  1'b0};
    tabla[3] = '{26,    3, 1,   1'b0, 1,   1'b0};
    tabla[4] = '{24,    3, 0,   1'b0, 0,   1'b0};
    tabla[5] = '{50,    3, 2,   1'b0, 2,   1'b0};
    tabla[6] = '{600,   3, 24,  1'b0, 24,  1'b0};
    tabla[7] = '{6375,  2, 255, 1'b0, 255, 1'b1};
    tabla[8] = '{2500,  2, 100, 1'b0, 100, 1'b0};

    // Wave held high through reset release, low at 50, rises at 100 and 600.
    #1;
    reset_FPGA_n = 1'b0;
    habilitar    = 1'b1;
    ciclos(3);
    chk("reset_periodo_a", periodo_a, 0);
    chk("reset_periodo_b", periodo_b, 0);
    chk("reset_valido_a", valido_a, 0);
    chk("reset_desborde_a", des_a, 0);
    chk("reset_sin_senal_a", sin_a, 1);
    chk("reset_sin_senal_b", sin_b, 1);
    reset_FPGA_n = 1'b1;
    s0 = strobes;
    ciclos(50);
    senal_in = 1'b0;
    ciclos(50);
    senal_in = 1'b1;
    ciclos(250);
    senal_in = 1'b0;
    ciclos(250);
    chk("alto_en_reset_sin_strobe", strobes, s0);
    senal_in = 1'b1;
    ciclos(6);
    chk("alto_en_reset_un_strobe", strobes, s0 + 1);
    chk("alto_en_reset_periodo_a", periodo_a, 20);
    chk("alto_en_reset_sin_senal", sin_a, 0);
    ciclos(244);
    senal_in = 1'b0;
    ciclos(100);

    foreach (tabla[i]) begin
      for (int k = 0; k < int'(tabla[i].n); k++)
        pulso(tabla[i].per_ciclos / 2, tabla[i].per_ciclos - tabla[i].per_ciclos / 2);
      chk("tabla_periodo_a", periodo_a, tabla[i].exp_a);
      chk("tabla_desborde_a", des_a, tabla[i].exp_des_a);
      chk("tabla_periodo_b", periodo_b, tabla[i].exp_b);
      chk("tabla_desborde_b", des_b, tabla[i].exp_des_b);
    end

    for (int k = 0; k < 30; k++) begin
      int unsigned p, h;
      p = $urandom_range(1000, 20);
      h = $urandom_range(p - 3, 2);
      pulso(int'(h), int'(p - h));
    end
    ciclos(10);

    // Enable dropped mid-period: value holds, two fresh edges needed.
    repeat (3) pulso(250, 250);
    chk("antes_abort_periodo_a", periodo_a, 20);
    pulso(500, 200);
    habilitar = 1'b0;
    ciclos(10);
    chk("deshab_valido_a", valido_a, 0);
    chk("deshab_periodo_a", periodo_a, 20);
    chk("deshab_sin_senal_a", sin_a, 1);
    habilitar = 1'b1;
    ciclos(290);
    s0 = strobes;
    pulso(500, 500);
    chk("rehab_primer_flanco", strobes, s0);
    chk("rehab_periodo_hold", periodo_a, 20);
    senal_in = 1'b1;
    ciclos(10);
    chk("rehab_segundo_flanco", strobes, s0 + 1);
    chk("rehab_periodo_a", periodo_a, 40);
    chk("rehab_periodo_b", periodo_b, 40);
    ciclos(490);
    senal_in = 1'b0;
    ciclos(500);

    // Asynchronous reset mid-period, sampled between clock edges.
    senal_in = 1'b1;
    ciclos(300);
    #7;
    reset_FPGA_n = 1'b0;
    #1;
    chk("abort_periodo_a", periodo_a, 0);
    chk("abort_periodo_b", periodo_b, 0);
    chk("abort_valido_a", valido_a, 0);
    chk("abort_desborde_a", des_a, 0);
    chk("abort_sin_senal_a", sin_a, 1);
    chk("abort_sin_senal_b", sin_b, 1);
    senal_in = 1'b0;
    ciclos(5);
    reset_FPGA_n = 1'b1;
    ciclos(20);

    // 300 us period: 8-bit instance saturates, then recovers on 100 us.
    senal_in = 1'b1;
    ciclos(100);
    chk("ovf_inicio_sin_senal_a", sin_a, 0);
    chk("ovf_inicio_sin_senal_b", sin_b, 0);
    ciclos(3650);
    senal_in = 1'b0;
    ciclos(2750);
    chk("ovf_saturado_sin_senal_b", sin_b, 1);
    chk("ovf_saturado_sin_senal_a", sin_a, 0);
    ciclos(1000);
    senal_in = 1'b1;
    ciclos(5);
    chk("ovf_periodo_b", periodo_b, 255);
    chk("ovf_desborde_b", des_b, 1);
    chk("ovf_periodo_a", periodo_a, 300);
    chk("ovf_desborde_a", des_a, 0);
    ciclos(1245);
    senal_in = 1'b0;
    ciclos(1250);
    senal_in = 1'b1;
    ciclos(5);
    chk("post_ovf_periodo_b", periodo_b, 100);
    chk("post_ovf_desborde_b", des_b, 0);
    ciclos(1245);
    senal_in = 1'b0;
    ciclos(20);
    chk("cola_pendiente", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
